bcd_disp_mux: RTL and testbench
===============================

BCD_DISP_MUX -- requirements
Module: bcd_disp_mux

Interface
REQ-001 Parameter DIG_CYCLES, default 50000, clk cycles each digit stays active (1 ms at 50 MHz); legal range 2..65535.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset; low forces reset state immediately regardless of clk.
REQ-004 load  input  1  single-cycle pulse; captures bcd3..bcd0 and dp_in into holding registers.
REQ-005 bcd3, bcd2, bcd1, bcd0  input  4 each  BCD digits, bcd3 most significant; sampled only when load=1.
REQ-006 dp_in  input  4  decimal-point request per digit, bit i for digit i; sampled only when load=1.
REQ-007 blank_en  input  1  level; enables leading-zero blanking; read live, not captured.
REQ-008 an  output  4  digit enables, active-low, one-hot-low while scanning.
REQ-009 sseg  output  8  segments, active-low; bit7=dp, bits6..0 = g,f,e,d,c,b,a.

Function
REQ-010 Prescaler counter SHALL count 0..DIG_CYCLES-1, then wrap to 0; a wrap asserts an internal advance tick for exactly one cycle.
REQ-011 The 2-bit digit index SHALL increment on each advance tick, sequence 0,1,2,3,0 (wraps modulo 4).
REQ-012 an and sseg SHALL be registered and SHALL update together on the edge after the index changes; they never show a mixed digit/segment pair.
REQ-013 an SHALL have exactly bit[index] low whenever the block is out of reset.
REQ-014 Holding registers SHALL update on any edge with load=1; load has no effect on prescaler or index.
REQ-015 Load-to-sseg latency SHALL be 2 cycles when the loaded digit is the active one.
REQ-016 Digit values 0..9 SHALL decode to standard active-low patterns: 0 -> 0xC0, 2 -> 0xA4, 4 -> 0x99 (dp off).
REQ-017 Holding values 10..15 SHALL display a dash (0xBF with dp off); such a digit counts as non-zero for blanking.
REQ-018 With blank_en=1, digit 3 SHALL be blanked if it is 0; digit 2 if digits 3 and 2 are both 0; digit 1 if digits 3..1 are all 0. Digit 0 is never blanked.
REQ-019 A digit with its held dp bit set SHALL never be blanked, and it terminates blanking for all lower digits.
REQ-020 A blanked digit SHALL output sseg=0xFF while its an bit is still driven low; the scan period is unchanged.
REQ-021 sseg bit7 SHALL be 0 exactly when the held dp bit of the active digit is 1.
REQ-022 A change of blank_en SHALL take effect at the next output register update, without waiting for load.

Reset
REQ-023 While reset is low: an=4'b1111, sseg=8'hFF, prescaler=0, index=0, holding digits=0, held dp=0.
REQ-024 On the first edge after reset release, outputs SHALL show digit 0 (an=4'b1110, sseg=0xC0); the index first advances after DIG_CYCLES cycles.
REQ-025 Reset asserted mid-scan or coincident with load SHALL discard the capture and force the REQ-023 values.

Structure
REQ-026 Shared package SHALL hold the 8-bit active-low segment constants (digits 0..9, dash, blank) and the DIG_CYCLES default.
REQ-027 One combinational sub-module, bcd_to_sseg (4-bit value + dp + blank -> 8-bit sseg), SHALL perform decoding; prescaler, index, holding registers and blanking logic stay in bcd_disp_mux.

Verification (DIG_CYCLES=4)
REQ-028 Reset held low, clk running -> an=1111, sseg=FF; after release, an=1110, sseg=C0, index advances every 4 cycles, an sequence 1110,1101,1011,0111,1110.
REQ-029 load with bcd=0,0,4,2, blank_en=1, dp=0 -> digits 3,2 give sseg=FF, digit 1 gives 99, digit 0 gives A4; with blank_en=0, digits 3,2 give C0.
REQ-030 load with bcd=0,0,0,0, dp_in=4'b0100, blank_en=1 -> digit 3 FF, digit 2 40, digit 1 C0, digit 0 C0.
REQ-031 load with bcd3=12, others 0, blank_en=1 -> digit 3 BF, digits 2..0 C0.
REQ-032 load pulse while digit 0 is active -> new digit 0 pattern appears 2 cycles later; an timing is unaffected.
REQ-033 reset pulled low mid-scan in the same cycle as load -> an=1111, sseg=FF immediately; after release the display shows 0 with no blanking (blank_en=0).

Source files
------------

// File: rtl/bcd_disp_mux_pkg.sv
// -----------------------------------------------------------------------------
// bcd_disp_mux_pkg
// Shared constants for the 4-digit multiplexed seven-segment driver:
//   - active-low segment patterns (bit7 = dp, bits6..0 = g,f,e,d,c,b,a)
//   - default per-digit dwell time in clk cycles
//   - helper mapping a digit index to its one-hot-low anode pattern
// -----------------------------------------------------------------------------
package bcd_disp_mux_pkg;

  // 1 ms per digit at 50 MHz
  localparam int unsigned DIG_CYCLES_DEF = 50000;

  // Active-low glyphs with the decimal point off (bit7 = 1)
  localparam logic [7:0] SSEG_0     = 8'hC0;
  localparam logic [7:0] SSEG_1     = 8'hF9;
  localparam logic [7:0] SSEG_2     = 8'hA4;
  localparam logic [7:0] SSEG_3     = 8'hB0;
  localparam logic [7:0] SSEG_4     = 8'h99;
  localparam logic [7:0] SSEG_5     = 8'h92;
  localparam logic [7:0] SSEG_6     = 8'h82;
  localparam logic [7:0] SSEG_7     = 8'hF8;
  localparam logic [7:0] SSEG_8     = 8'h80;
  localparam logic [7:0] SSEG_9     = 8'h90;
  localparam logic [7:0] SSEG_DASH  = 8'hBF;
  localparam logic [7:0] SSEG_BLANK = 8'hFF;

  // Anode enables are active-low: only the selected digit's bit is 0
  function automatic logic [3:0] an_for_index(input logic [1:0] idx);
    logic [3:0] an_v;
    case (idx)
      2'd0:    an_v = 4'b1110;
      2'd1:    an_v = 4'b1101;
      2'd2:    an_v = 4'b1011;
      2'd3:    an_v = 4'b0111;
      default: an_v = 4'b1111;
    endcase
    return an_v;
  endfunction

endpackage

// File: rtl/bcd_disp_mux_bcd_to_sseg.sv
// -----------------------------------------------------------------------------
// bcd_to_sseg
// Purely combinational digit decoder.
//   val   [3:0] in  : held digit value; 0..9 decode normally, 10..15 show a dash
//   dp          in  : 1 lights the decimal point
//   blank       in  : 1 forces all segments off (overrides val and dp)
//   sseg  [7:0] out : active-low segments, bit7 = dp, bits6..0 = g..a
// -----------------------------------------------------------------------------
module bcd_to_sseg
  import bcd_disp_mux_pkg::*;
(
  input  logic [3:0] val,
  input  logic       dp,
  input  logic       blank,
  output logic [7:0] sseg
);

  logic [7:0] glyph_s;

  // Glyph lookup followed by blank / dp overlay
  always_comb begin
    glyph_s = SSEG_DASH;
    case (val)
      4'd0:    glyph_s = SSEG_0;
      4'd1:    glyph_s = SSEG_1;
      4'd2:    glyph_s = SSEG_2;
      4'd3:    glyph_s = SSEG_3;
      4'd4:    glyph_s = SSEG_4;
      4'd5:    glyph_s = SSEG_5;
      4'd6:    glyph_s = SSEG_6;
      4'd7:    glyph_s = SSEG_7;
      4'd8:    glyph_s = SSEG_8;
      4'd9:    glyph_s = SSEG_9;
      default: glyph_s = SSEG_DASH;
    endcase

    if (blank) begin
      sseg = SSEG_BLANK;
    end else if (dp) begin
      sseg = {1'b0, glyph_s[6:0]};
    end else begin
      sseg = glyph_s;
    end
  end

endmodule

// File: rtl/bcd_disp_mux.sv
// -----------------------------------------------------------------------------
// bcd_disp_mux
// Time-multiplexed driver for a 4-digit common-anode seven-segment display.
//   clk            in  : sole clock, rising edge
//   reset          in  : asynchronous, active-low
//   load           in  : one-cycle pulse capturing bcd3..bcd0 and dp_in
//   bcd3..bcd0 [3:0] in: digit values, bcd3 most significant
//   dp_in      [3:0] in: decimal-point request, bit i for digit i
//   blank_en       in  : live level enabling leading-zero blanking
//   an         [3:0] out: registered anode enables, active-low, one-hot-low
//   sseg       [7:0] out: registered segments, active-low, bit7 = dp
// Each digit stays active for DIG_CYCLES clk cycles (legal 2..65535).
// -----------------------------------------------------------------------------
module bcd_disp_mux
  import bcd_disp_mux_pkg::*;
#(
  parameter int unsigned DIG_CYCLES = DIG_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] bcd3,
  input  logic [3:0] bcd2,
  input  logic [3:0] bcd1,
  input  logic [3:0] bcd0,
  input  logic [3:0] dp_in,
  input  logic       blank_en,
  output logic [3:0] an,
  output logic [7:0] sseg
);

  localparam logic [15:0] PRESC_MAX = 16'(DIG_CYCLES - 1);

  logic [15:0]     presc_r;
  logic [1:0]      idx_r;
  logic [3:0][3:0] hold_r;
  logic [3:0]      dp_r;
  logic [3:0]      an_r;
  logic [7:0]      sseg_r;

  logic            tick_s;
  logic [3:0]      nz_s;
  logic [3:0]      blank_s;
  logic [3:0]      act_val_s;
  logic            act_dp_s;
  logic            act_blank_s;
  logic [7:0]      dec_sseg_s;

  assign tick_s = (presc_r == PRESC_MAX);

  // Prescaler and digit index; index steps once per prescaler wrap
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_r <= 16'd0;
      idx_r   <= 2'd0;
    end else if (tick_s) begin
      presc_r <= 16'd0;
      idx_r   <= idx_r + 2'd1;
    end else begin
      presc_r <= presc_r + 16'd1;
    end
  end

  // Holding registers for digit values and decimal points
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_r <= '0;
      dp_r   <= 4'b0000;
    end else if (load) begin
      hold_r <= {bcd3, bcd2, bcd1, bcd0};
      dp_r   <= dp_in;
    end else begin
      hold_r <= hold_r;
      dp_r   <= dp_r;
    end
  end

  // Leading-zero blanking chain from the MSD down; a non-zero value
  // (including 10..15) or a lit dp stops the chain for all lower digits
  always_comb begin
    nz_s[0]    = (hold_r[0] != 4'd0);
    nz_s[1]    = (hold_r[1] != 4'd0);
    nz_s[2]    = (hold_r[2] != 4'd0);
    nz_s[3]    = (hold_r[3] != 4'd0);
    blank_s[3] = blank_en & ~nz_s[3] & ~dp_r[3];
    blank_s[2] = blank_s[3] & ~nz_s[2] & ~dp_r[2];
    blank_s[1] = blank_s[2] & ~nz_s[1] & ~dp_r[1];
    blank_s[0] = 1'b0;
  end

  // Select the active digit's value, dp and blank flag for decoding
  always_comb begin
    act_val_s   = hold_r[idx_r];
    act_dp_s    = dp_r[idx_r];
    act_blank_s = blank_s[idx_r];
  end

  bcd_to_sseg u_dec (
    .val   (act_val_s),
    .dp    (act_dp_s),
    .blank (act_blank_s),
    .sseg  (dec_sseg_s)
  );

  // an and sseg share one register stage so they always change together
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      an_r   <= 4'b1111;
      sseg_r <= SSEG_BLANK;
    end else begin
      an_r   <= an_for_index(idx_r);
      sseg_r <= dec_sseg_s;
    end
  end

  assign an   = an_r;
  assign sseg = sseg_r;

endmodule

// File: tb/tb_bcd_disp_mux.sv
// -----------------------------------------------------------------------------
// tb_bcd_disp_mux
// Directed bench for bcd_disp_mux with DIG_CYCLES = 4. Outputs are sampled
// on the falling edge; inputs change on the falling edge.
// -----------------------------------------------------------------------------
module tb_bcd_disp_mux;

  logic       clk;
  logic       reset;
  logic       load;
  logic [3:0] bcd3, bcd2, bcd1, bcd0;
  logic [3:0] dp_in;
  logic       blank_en;
  logic [3:0] an;
  logic [7:0] sseg;

  int total_cnt = 0;
  int pass_cnt  = 0;

  bcd_disp_mux #(.DIG_CYCLES(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .bcd3     (bcd3),
    .bcd2     (bcd2),
    .bcd1     (bcd1),
    .bcd0     (bcd0),
    .dp_in    (dp_in),
    .blank_en (blank_en),
    .an       (an),
    .sseg     (sseg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total_cnt++;
    if (obs === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge where an equals want (bounded)
  task automatic wait_an(input logic [3:0] want, input string tag);
    int n;
    n = 0;
    while (an !== want && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (an !== want) begin
      check({tag, "_timeout"}, {12'd0, an}, {12'd0, want});
    end
  endtask

  // One-cycle load pulse, issued on a falling edge
  task automatic do_load(input logic [3:0] d3, input logic [3:0] d2,
                         input logic [3:0] d1, input logic [3:0] d0,
                         input logic [3:0] dp);
    bcd3  = d3;
    bcd2  = d2;
    bcd1  = d1;
    bcd0  = d0;
    dp_in = dp;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
  endtask

  // Let the outputs refresh, then check each digit's pattern when it is active
  task automatic check_scan(input string tag, input logic [7:0] e3, input logic [7:0] e2,
                            input logic [7:0] e1, input logic [7:0] e0);
    logic [7:0] exp_v [4];
    exp_v[0] = e0;
    exp_v[1] = e1;
    exp_v[2] = e2;
    exp_v[3] = e3;
    repeat (2) @(negedge clk);
    for (int d = 3; d >= 0; d--) begin
      logic [3:0] want;
      want = 4'b1111;
      want[d] = 1'b0;
      wait_an(want, tag);
      check($sformatf("%s_d%0d", tag, d), {8'd0, sseg}, {8'd0, exp_v[d]});
    end
  endtask

  initial begin
    reset    = 1'b0;
    load     = 1'b0;
    bcd3     = 4'd0;
    bcd2     = 4'd0;
    bcd1     = 4'd0;
    bcd0     = 4'd0;
    dp_in    = 4'd0;
    blank_en = 1'b0;

    // Reset held with clock running
    repeat (3) @(negedge clk);
    check("rst_an", {12'd0, an}, 16'h000F);
    check("rst_sseg", {8'd0, sseg}, 16'h00FF);

    // Release; first edge shows digit 0, then one digit every 4 cycles
    reset = 1'b1;
    @(negedge clk);
    check("rel_an", {12'd0, an}, 16'h000E);
    check("rel_sseg", {8'd0, sseg}, 16'h00C0);
    repeat (3) @(negedge clk);
    check("seq_an0_hold", {12'd0, an}, 16'h000E);
    @(negedge clk);
    check("seq_an1", {12'd0, an}, 16'h000D);
    repeat (4) @(negedge clk);
    check("seq_an2", {12'd0, an}, 16'h000B);
    repeat (4) @(negedge clk);
    check("seq_an3", {12'd0, an}, 16'h0007);
    repeat (4) @(negedge clk);
    check("seq_an0", {12'd0, an}, 16'h000E);

    // Load while digit 0 has just become active: new glyph after 2 edges
    wait_an(4'b0111, "lat_pre");
    wait_an(4'b1110, "lat_start");
    do_load(4'd0, 4'd0, 4'd0, 4'd4, 4'b0000);
    check("lat_1cyc", {8'd0, sseg}, 16'h00C0);
    @(negedge clk);
    check("lat_2cyc", {8'd0, sseg}, 16'h0099);
    check("lat_an", {12'd0, an}, 16'h000E);
    @(negedge clk);
    check("lat_an_hold", {12'd0, an}, 16'h000E);
    @(negedge clk);
    check("lat_an_next", {12'd0, an}, 16'h000D);

    // Leading-zero blanking, then the same data unblanked
    blank_en = 1'b1;
    do_load(4'd0, 4'd0, 4'd4, 4'd2, 4'b0000);
    check_scan("blk0042", 8'hFF, 8'hFF, 8'h99, 8'hA4);
    blank_en = 1'b0;
    check_scan("noblk0042", 8'hC0, 8'hC0, 8'h99, 8'hA4);

    // dp on digit 2 stops blanking below it
    blank_en = 1'b1;
    do_load(4'd0, 4'd0, 4'd0, 4'd0, 4'b0100);
    check_scan("dp2", 8'hFF, 8'h40, 8'hC0, 8'hC0);

    // Value 12 shows a dash and counts as non-zero
    do_load(4'd12, 4'd0, 4'd0, 4'd0, 4'b0000);
    check_scan("dash", 8'hBF, 8'hC0, 8'hC0, 8'hC0);

    // Only the MSD is blanked when digit 2 is non-zero
    do_load(4'd0, 4'd3, 4'd0, 4'd0, 4'b0000);
    check_scan("blk_msd", 8'hFF, 8'hB0, 8'hC0, 8'hC0);

    // Digit 0 is never blanked; its dp lights
    do_load(4'd0, 4'd0, 4'd0, 4'd7, 4'b0001);
    check_scan("d0dp", 8'hFF, 8'hFF, 8'hFF, 8'h78);

    // Reset asserted mid-scan together with load
    blank_en = 1'b0;
    repeat (2) @(negedge clk);
    bcd3  = 4'd9;
    bcd2  = 4'd9;
    bcd1  = 4'd9;
    bcd0  = 4'd9;
    dp_in = 4'b1111;
    load  = 1'b1;
    reset = 1'b0;
    #1;
    check("mid_rst_an", {12'd0, an}, 16'h000F);
    check("mid_rst_sseg", {8'd0, sseg}, 16'h00FF);
    @(negedge clk);
    load = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("post_rst_an", {12'd0, an}, 16'h000E);
    check("post_rst_sseg", {8'd0, sseg}, 16'h00C0);
    check_scan("post_rst", 8'hC0, 8'hC0, 8'hC0, 8'hC0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
